// File: rtl/ysyx_25030085_ifu.sv
// Instruction fetch unit: owns the PC, issues one imem fetch at a time and queues {pc, inst} for the decoder.
// Optional feature macro: YSYX_25030085_EBREAK_HALT_EN (stop fetching once an ebreak has been queued).
module ysyx_25030085_ifu #(
    parameter logic [31:0] RESET_PC   = 32'h8000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        halted
);

    localparam int               PTR_W   = $clog2(FIFO_DEPTH);
    localparam int               CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
`ifdef YSYX_25030085_EBREAK_HALT_EN
    localparam logic [31:0]      EBREAK  = 32'h0010_0073;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HALT
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      req_pc_q, req_pc_d;
    logic             drop_q, drop_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      fifo_inst_q [FIFO_DEPTH];
    logic [31:0]      fifo_pc_q   [FIFO_DEPTH];
    logic             push;
    logic             pop;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        drop_d   = drop_q;
        push     = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A fetch is only launched when its response is guaranteed a FIFO slot.
                if (drop_q) begin
                    if (imem_rsp_valid) begin
                        drop_d = 1'b0;
                    end
                end else if (count_q < DEPTH_C) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (imem_req_ready) begin
                    state_d  = S_WAIT;
                    req_pc_d = pc_q;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    push = 1'b1;
                    pc_d = req_pc_q + 32'd4;
`ifdef YSYX_25030085_EBREAK_HALT_EN
                    state_d = (imem_rsp_data == EBREAK) ? S_HALT : S_IDLE;
`else
                    state_d = S_IDLE;
`endif
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase

        // Redirect wins over everything; remember whether a response is still owed to us.
        if (redirect_valid) begin
            push    = 1'b0;
            state_d = S_IDLE;
            pc_d    = redirect_pc & 32'hFFFF_FFFC;
            drop_d  = ((state_q == S_WAIT) && !imem_rsp_valid)
                   || ((state_q == S_REQ) && imem_req_ready)
                   || (drop_q && !imem_rsp_valid);
        end
    end

    always_comb begin
        pop      = (count_q != '0) && inst_ready;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (redirect_valid) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (!push && pop) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            req_pc_q <= RESET_PC;
            drop_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            drop_q   <= drop_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Queue storage carries no reset; occupancy is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_inst_q[wr_ptr_q] <= imem_rsp_data;
            fifo_pc_q[wr_ptr_q]   <= req_pc_q;
        end
    end

    assign imem_req_valid = (state_q == S_REQ);
    assign imem_req_addr  = pc_q;
    assign inst_valid     = (count_q != '0);
    assign inst           = inst_valid ? fifo_inst_q[rd_ptr_q] : 32'd0;
    assign inst_pc        = inst_valid ? fifo_pc_q[rd_ptr_q] : 32'd0;

`ifdef YSYX_25030085_EBREAK_HALT_EN
    assign halted = (state_q == S_HALT) && (count_q == '0);
`else
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_25030085_ifu.sv
// Self-checking bench for ysyx_25030085_ifu: directed scenarios plus randomized traffic against a stream-level model.
module tb_ysyx_25030085_ifu;

    localparam logic [31:0] RESET_PC   = 32'h8000_0000;
    localparam int          FIFO_DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        halted;

    always #5 clk = ~clk;

    ysyx_25030085_ifu #(
        .RESET_PC  (RESET_PC),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst          (inst),
        .inst_pc       (inst_pc),
        .halted        (halted)
    );

    int checks_total  = 0;
    int checks_passed = 0;

    // Stimulus knobs (percentages, per-mille for redirects, response latency range).
    int          p_ready, p_iready, p_redir, min_lat, max_lat;
    bit          redir_req;
    logic [31:0] redir_tgt;
    bit          ebreak_en;

    // Reference model: the expected fetch stream and the expected decoder stream.
    logic [31:0] exp_req_pc, exp_pop_pc, pend_addr, last_req_addr, last_pop_pc;
    int          pend, n_req, n_pop, mark;
    bit          redir_last;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        if (obs === exp) checks_passed++;
        else $display("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (ebreak_en && a == 32'h8000_0010) return 32'h0010_0073;
        if (a == 32'h8000_0000) return 32'h0050_0093;
        if (a == 32'h8000_0004) return 32'h0010_0113;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    // Called at a falling edge: check this cycle's outputs, drive inputs, advance the model across the next rising edge.
    task automatic cycle();
        check_eq("one_outstanding", {31'd0, imem_req_valid && (pend > 0)}, 32'd0);
        if (!inst_valid) begin
            check_eq("empty_inst", inst, 32'd0);
            check_eq("empty_pc", inst_pc, 32'd0);
        end
        if (redir_last) check_eq("flush_valid", {31'd0, inst_valid}, 32'd0);
`ifndef YSYX_25030085_EBREAK_HALT_EN
        check_eq("halted_tied", {31'd0, halted}, 32'd0);
`endif
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'd0;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(pend_addr);
            end
        end
        imem_req_ready = (int'($urandom_range(99)) < p_ready);
        inst_ready     = (int'($urandom_range(99)) < p_iready);
        redirect_valid = 1'b0;
        if (redir_req) begin
            redirect_valid = 1'b1;
            redirect_pc    = redir_tgt;
            redir_req      = 1'b0;
        end else if (int'($urandom_range(999)) < p_redir) begin
            redirect_valid = 1'b1;
            redirect_pc    = 32'h8000_0000 + 32'($urandom_range(1023));
        end

        if (imem_req_valid && imem_req_ready) begin
            check_eq("req_addr", imem_req_addr, exp_req_pc);
            exp_req_pc    = exp_req_pc + 32'd4;
            last_req_addr = imem_req_addr;
            pend_addr     = imem_req_addr;
            pend          = int'($urandom_range(max_lat, min_lat));
            n_req++;
        end
        if (inst_valid && inst_ready) begin
            check_eq("pop_pc", inst_pc, exp_pop_pc);
            check_eq("pop_inst", inst, mem_word(exp_pop_pc));
            exp_pop_pc  = exp_pop_pc + 32'd4;
            last_pop_pc = inst_pc;
            n_pop++;
        end
        if (redirect_valid) begin
            exp_req_pc = redirect_pc & 32'hFFFF_FFFC;
            exp_pop_pc = exp_req_pc;
        end
        redir_last = redirect_valid;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_eq("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check_eq("rst_req_addr", imem_req_addr, RESET_PC);
        check_eq("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        check_eq("rst_inst", inst, 32'd0);
        check_eq("rst_inst_pc", inst_pc, 32'd0);
        check_eq("rst_halted", {31'd0, halted}, 32'd0);
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b0;
        inst_ready     = 1'b0;
        exp_req_pc     = RESET_PC;
        exp_pop_pc     = RESET_PC;
        redir_last     = 1'b0;
        // A response still owed from before reset lands in the first idle cycle and must be ignored.
        if (pend > 0) pend = 1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_eq("idle_after_release", {31'd0, imem_req_valid}, 32'd0);
    endtask

    task automatic run_until_req(input string tag);
        int start;
        start = n_req;
        for (int i = 0; i < 40 && n_req == start; i++) cycle();
        check_eq(tag, {31'd0, n_req > start}, 32'd1);
    endtask

    task automatic run_until_pop(input string tag);
        int start;
        start = n_pop;
        for (int i = 0; i < 40 && n_pop == start; i++) cycle();
        check_eq(tag, {31'd0, n_pop > start}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b1;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'd0;
        redirect_valid = 1'b0; redirect_pc = 32'd0; inst_ready = 1'b0;
        pend = 0; n_req = 0; n_pop = 0; mark = 0;
        redir_req = 1'b0; redir_tgt = 32'd0; ebreak_en = 1'b0; redir_last = 1'b0;
        last_req_addr = 32'd0; last_pop_pc = 32'd0; pend_addr = 32'd0;
        p_ready = 100; p_iready = 100; p_redir = 0; min_lat = 1; max_lat = 1;
        #2;
        do_reset();

        // First two fetches after reset with zero-wait memory.
        cycle();
        check_eq("first_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check_eq("first_req_addr", imem_req_addr, RESET_PC);
        run_until_pop("pop0_seen");
        check_eq("pop0_pc", last_pop_pc, 32'h8000_0000);
        run_until_pop("pop1_seen");
        check_eq("pop1_pc", last_pop_pc, 32'h8000_0004);

        // Steady-state throughput: one instruction every three cycles.
        repeat (3) cycle();
        mark = n_pop;
        repeat (30) cycle();
        check_eq("throughput", 32'(n_pop - mark), 32'd10);

        // Decoder stalled: only FIFO_DEPTH fetches go out, then fetching resumes in order.
        do_reset();
        p_iready = 0;
        mark = n_req;
        repeat (15) cycle();
        check_eq("reserve_reqs", 32'(n_req - mark), 32'(FIFO_DEPTH));
        check_eq("reserve_idle", {31'd0, imem_req_valid}, 32'd0);
        p_iready = 100;
        run_until_req("resume_seen");
        check_eq("resume_addr", last_req_addr, 32'h8000_0008);

        // Redirect while a response is outstanding.
        min_lat = 3; max_lat = 3;
        run_until_req("pre_redirect_req");
        redir_req = 1'b1; redir_tgt = 32'h8000_0103;
        cycle();
        run_until_req("post_redirect_req");
        check_eq("post_redirect_addr", last_req_addr, 32'h8000_0100);
        run_until_pop("post_redirect_pop");
        check_eq("post_redirect_pc", last_pop_pc, 32'h8000_0100);

        // Memory not ready: request held with a stable address.
        min_lat = 1; max_lat = 1;
        do_reset();
        p_ready = 0;
        cycle();
        for (int i = 0; i < 5; i++) begin
            check_eq("stall_valid", {31'd0, imem_req_valid}, 32'd1);
            check_eq("stall_addr", imem_req_addr, RESET_PC);
            cycle();
        end
        p_ready = 100;

        // PC wraps around the top of the address space.
        redir_req = 1'b1; redir_tgt = 32'hFFFF_FFF8;
        cycle();
        run_until_pop("wrap_pop0");
        run_until_pop("wrap_pop1");
        run_until_pop("wrap_pop2");
        check_eq("wrap_pc", last_pop_pc, 32'h0000_0000);

        // Reset asserted while waiting for a response.
        min_lat = 3; max_lat = 3;
        run_until_req("pre_reset_req");
        do_reset();
        run_until_req("after_reset_req");
        check_eq("after_reset_addr", last_req_addr, RESET_PC);
        run_until_pop("after_reset_pop");
        check_eq("after_reset_pc", last_pop_pc, RESET_PC);

        // Randomized traffic: backpressure on both sides, variable latency, random redirects.
        p_ready = 60; p_iready = 60; p_redir = 20; min_lat = 1; max_lat = 3;
        mark = n_pop;
        repeat (3000) cycle();
        check_eq("random_progress", {31'd0, n_pop > mark + 100}, 32'd1);
        p_redir = 0;

`ifdef YSYX_25030085_EBREAK_HALT_EN
        // ebreak stops fetching; a redirect restarts it.
        p_ready = 100; p_iready = 100; min_lat = 1; max_lat = 1;
        do_reset();
        ebreak_en = 1'b1;
        redir_req = 1'b1; redir_tgt = 32'h8000_0010;
        cycle();
        run_until_pop("ebreak_pop");
        check_eq("ebreak_pc", last_pop_pc, 32'h8000_0010);
        check_eq("halted_set", {31'd0, halted}, 32'd1);
        mark = n_req;
        repeat (6) cycle();
        check_eq("halt_no_req", 32'(n_req - mark), 32'd0);
        check_eq("halted_hold", {31'd0, halted}, 32'd1);
        redir_req = 1'b1; redir_tgt = RESET_PC;
        cycle();
        check_eq("halted_clear", {31'd0, halted}, 32'd0);
        ebreak_en = 1'b0;
        run_until_req("restart_req");
        check_eq("restart_addr", last_req_addr, RESET_PC);
`endif

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/ysyx_25030085_ifu.md
# ysyx_25030085_ifu

Instruction fetch unit for the ysyx_25030085 core, sitting directly upstream of the instruction memory and downstream-feeding the decoder. It owns the PC register, issues one word-aligned fetch at a time over a valid/ready request + valid response memory port, and buffers returned instructions, each tagged with its PC, in a small FIFO drained by the decoder over valid/ready. A redirect from execute flushes the FIFO and discards any in-flight response.

## Interface
- RESET_PC, 32'h8000_0000, PC of first fetch after reset
- FIFO_DEPTH, 2, instruction queue entries; power of two, ≥2
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  32  fetch address, bits [1:0] always 0
- imem_rsp_valid  in  1  response valid, one cycle per accepted request
- imem_rsp_data  in  32  instruction word
- redirect_valid  in  1  control-flow redirect, single-cycle pulse
- redirect_pc  in  32  new PC; bits [1:0] ignored, forced to 0
- inst_valid  out  1  FIFO head valid
- inst_ready  in  1  decoder consumes head
- inst  out  32  head instruction, 0 when empty
- inst_pc  out  32  head PC, 0 when empty
- halted  out  1  fetch stopped on ebreak and FIFO drained

## Operation
- FSM: IDLE, REQ, WAIT, HALT. imem_req_valid = (state==REQ); imem_req_addr = pc.
- IDLE→REQ when entries + 0 < FIFO_DEPTH (space reserved for one outstanding fetch).
- REQ→WAIT on imem_req_valid & imem_req_ready; req_pc latched = pc.
- WAIT→IDLE on imem_rsp_valid: push {req_pc, imem_rsp_data} unless drop flag set; pc ← req_pc + 4 on push. At most one request outstanding.
- In REQ, request stays asserted with stable address until accepted (except on redirect).
- Redirect (highest priority, any state): FIFO flushed, pc ← {redirect_pc[31:2],2'b00}, state→IDLE. If a request is outstanding (WAIT, or accepted the same cycle), set drop; the next response is discarded and clears drop. IDLE does not leave while drop is set.
- A response arriving in the same cycle as a redirect is discarded; drop is not set by it.
- FIFO: push and pop may occur in the same cycle; overflow impossible by reservation rule. Pop on inst_valid & inst_ready.
- pc arithmetic is 32-bit, wraps 0xFFFF_FFFC→0x0000_0000.

## Timing
- Reset (async assert, sync release): state IDLE, pc = RESET_PC, FIFO empty, drop 0; outputs imem_req_valid 0, imem_req_addr RESET_PC, inst_valid 0, inst 0, inst_pc 0, halted 0.
- First imem_req_valid in the first cycle after the first rising edge with rst_n high.
- Response→inst_valid: 1 cycle (registered FIFO). With zero-wait memory (ready=1, response 1 cycle after accept), throughput is one instruction per 3 cycles.
- Redirect in cycle N: inst_valid 0 in cycle N+1; new request no earlier than N+1.
- Reset mid-operation clears everything immediately; an outstanding memory response after reset release is ignored (state IDLE, not WAIT).

## Configuration
- YSYX_25030085_EBREAK_HALT_EN defined: pushing 32'h0010_0073 moves FSM to HALT instead of IDLE; no further requests. halted = (state==HALT) & FIFO empty. Redirect leaves HALT (to IDLE).
- Undefined: ebreak is an ordinary instruction; HALT is unreachable; halted tied 0.

## Test plan
- Reset release, ready=1, 1-cycle responses 0x00500093, 0x00100113, inst_ready=1 -> req addrs 0x8000_0000, 0x8000_0004; inst/inst_pc pairs (0x00500093, 0x8000_0000), (0x00100113, 0x8000_0004).
- inst_ready=0, FIFO_DEPTH=2 -> exactly 2 requests issued, then imem_req_valid stays 0; raising inst_ready resumes at 0x8000_0008.
- Redirect to 0x8000_0103 while in WAIT -> stale response dropped; next req addr 0x8000_0100; first inst_pc 0x8000_0100.
- imem_req_ready held 0 for 5 cycles -> imem_req_valid and addr 0x8000_0000 stable all 5 cycles.
- With macro: fetch 0x00100073 at 0x8000_0010 -> no request to 0x8000_0014; halted=1 the cycle after decoder pops it; redirect to 0x8000_0000 clears halted and restarts fetch.
- Assert rst_n=0 during WAIT -> all outputs reset values in same cycle; after release, first req 0x8000_0000.
